// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle for the N-to-1 stream selector: NUM_IN producer channels
// feeding one registered output toward a single shared consumer.
interface stream_mux_nto1_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int SEL_W  = 5
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        grant;

    // Environment side: producers, address source and consumer
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, grant
    );

    // Selector side
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, grant
    );
endinterface

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 word selector with valid/ready on every channel.
// MODE 0 picks the channel addressed by sel; MODE 1 arbitrates round-robin
// over the valid channels. One output register gives full throughput.
module stream_mux_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int SEL_W  = 5,
    parameter int MODE   = 0
) (
    input logic              clk,
    input logic              rst_n,
    stream_mux_nto1_if.slave bus
);
    localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  rr_win;
    logic              rr_found;
    logic              addr_ok;
    logic [SEL_W-1:0]  win;
    logic              win_ok;
    logic [NUM_IN-1:0] win_onehot;
    logic              win_valid;
    logic              can_accept;
    logic              xfer;
    logic [WIDTH-1:0]  win_data;

    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [SEL_W-1:0]  grant_q;

    // Round-robin search: first valid channel after ptr, wrapping at NUM_IN-1
    always_comb begin
        logic [SEL_W:0] idx;
        idx      = '0;
        rr_found = 1'b0;
        rr_win   = '0;
        // One extra index bit keeps ptr+i from overflowing before the wrap
        for (int unsigned i = 1; i <= NUM_IN; i++) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(i);
            if (idx >= N_EXT)
                idx = idx - N_EXT;
            if (!rr_found && (|(bus.in_valid & (NUM_IN'(1) << idx)))) begin
                rr_found = 1'b1;
                rr_win   = idx[SEL_W-1:0];
            end
        end
    end

    // Winner selection, handshake and transfer qualification
    always_comb begin
        addr_ok    = ({1'b0, bus.sel} < N_EXT);
        win        = (MODE == 1) ? rr_win   : bus.sel;
        win_ok     = (MODE == 1) ? rr_found : addr_ok;
        win_onehot = NUM_IN'(1) << win;
        win_valid  = |(bus.in_valid & win_onehot);
        can_accept = !valid_q || bus.out_ready;
        xfer       = can_accept && win_ok && win_valid;
        bus.in_ready = (can_accept && win_ok) ? win_onehot : '0;
    end

    // Data path mux for the winning channel
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (win == SEL_W'(k))
                win_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // Output register and round-robin pointer; drain keeps data/grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ptr     <= LAST;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= win_data;
            grant_q <= win;
            ptr     <= win;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.grant     = grant_q;
endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1: address mode at 32 and 20 channels,
// round-robin mode at 4 channels, backpressure, drain/fill and async reset.
module tb_stream_mux_nto1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stream_mux_nto1_if #(.WIDTH(32), .NUM_IN(32), .SEL_W(5)) b0 ();
    stream_mux_nto1_if #(.WIDTH(32), .NUM_IN(20), .SEL_W(5)) b1 ();
    stream_mux_nto1_if #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2)) b2 ();

    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(32), .SEL_W(5), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(20), .SEL_W(5), .MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2), .MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    typedef struct {
        logic [4:0]  sel;
        logic        ordy;
        logic [31:0] vld;
        logic [31:0] exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [4:0]  exp_g;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int s, input logic r, input logic [31:0] v,
                                input logic [31:0] er, input logic eo,
                                input logic [31:0] ed, input int eg);
        vec_t t;
        t.sel      = s[4:0];
        t.ordy     = r;
        t.vld      = v;
        t.exp_rdy  = er;
        t.exp_ov   = eo;
        t.exp_data = ed;
        t.exp_g    = eg[4:0];
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        int rcv;

        b0.in_valid = '0; b0.out_ready = 1'b0; b0.sel = '0;
        b1.in_valid = '0; b1.out_ready = 1'b0; b1.sel = '0;
        b2.in_valid = '0; b2.out_ready = 1'b0; b2.sel = '0;
        for (int k = 0; k < 32; k++) b0.in_data[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 20; k++) b1.in_data[k*32 +: 32] = 32'hB000_0000 + k;
        for (int k = 0; k < 4;  k++) b2.in_data[k*32 +: 32] = 32'hC000_0000 + k;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov0", b0.out_valid, 0); chk("rst_d0", b0.out_data, 0); chk("rst_g0", b0.grant, 0);
        chk("rst_ov1", b1.out_valid, 0); chk("rst_d1", b1.out_data, 0); chk("rst_g1", b1.grant, 0);
        chk("rst_ov2", b2.out_valid, 0); chk("rst_d2", b2.out_data, 0); chk("rst_g2", b2.grant, 0);
        rst_n = 1'b1;

        // T1 sweep, T2 backpressure, then drain without fill
        for (int k = 0; k < 32; k++)
            vt.push_back(mk(k, 1'b1, '1, 32'd1 << k, 1'b1, 32'hA000_0000 + k, k));
        vt.push_back(mk(7, 1'b1, '1, 32'd1 << 7, 1'b1, 32'hA000_0007, 7));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(7, 1'b0, '1, 32'd0, 1'b1, 32'hA000_0007, 7));
        vt.push_back(mk(7, 1'b1, '1, 32'd1 << 7, 1'b1, 32'hA000_0007, 7));
        vt.push_back(mk(8, 1'b1, '1, 32'd1 << 8, 1'b1, 32'hA000_0008, 8));
        vt.push_back(mk(8, 1'b1, '0, 32'd1 << 8, 1'b0, 32'hA000_0008, 8));
        vt.push_back(mk(8, 1'b0, '0, 32'd1 << 8, 1'b0, 32'hA000_0008, 8));

        foreach (vt[i]) begin
            b0.sel       = vt[i].sel;
            b0.out_ready = vt[i].ordy;
            b0.in_valid  = vt[i].vld;
            @(negedge clk);
            chk($sformatf("m0_rdy[%0d]", i), b0.in_ready, vt[i].exp_rdy);
            @(posedge clk); #1;
            chk($sformatf("m0_ov[%0d]", i), b0.out_valid, vt[i].exp_ov);
            chk($sformatf("m0_data[%0d]", i), b0.out_data, vt[i].exp_data);
            chk($sformatf("m0_g[%0d]", i), b0.grant, vt[i].exp_g);
        end
        b0.in_valid = '0; b0.out_ready = 1'b0;

        // T3: NUM_IN=20, last legal address then out-of-range address
        b1.in_valid = '1; b1.out_ready = 1'b1;
        b1.sel = 5'd3;
        @(negedge clk); chk("t3_rdy3", b1.in_ready, 32'd1 << 3);
        @(posedge clk); #1;
        chk("t3_ov3", b1.out_valid, 1); chk("t3_d3", b1.out_data, 32'hB000_0003); chk("t3_g3", b1.grant, 3);
        b1.sel = 5'd19;
        @(negedge clk); chk("t3_rdy19", b1.in_ready, 32'd1 << 19);
        @(posedge clk); #1;
        chk("t3_d19", b1.out_data, 32'hB000_0013); chk("t3_g19", b1.grant, 19);
        b1.sel = 5'd25;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); chk("t3_rdy25", b1.in_ready, 0);
            @(posedge clk); #1;
            chk("t3_ov25", b1.out_valid, 0);
            chk("t3_d25", b1.out_data, 32'hB000_0013);
            chk("t3_g25", b1.grant, 19);
        end
        b1.in_valid = '0; b1.out_ready = 1'b0;

        // T4: round robin, all valid then channels 1 and 3, then channel 2 alone
        b2.in_valid = 4'hF; b2.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk); chk("t4_rdy_all", b2.in_ready, 32'd1 << (n % 4));
            @(posedge clk); #1;
            chk("t4_g_all", b2.grant, n % 4);
            chk("t4_d_all", b2.out_data, 32'hC000_0000 + (n % 4));
            chk("t4_ov_all", b2.out_valid, 1);
        end
        b2.in_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("t4_g_13", b2.grant, (n % 2 == 0) ? 1 : 3);
        end
        b2.in_valid = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("t4_g_2", b2.grant, 2);
            chk("t4_ov_2", b2.out_valid, 1);
        end
        b2.in_valid = 4'b0000;
        @(negedge clk); chk("t4_rdy_none", b2.in_ready, 0);
        @(posedge clk); #1;
        chk("t4_drain_ov", b2.out_valid, 0);
        chk("t4_drain_g", b2.grant, 2);

        // T5: reset pulse, then out_ready pattern 1,0,1 with a consumer scoreboard
        rst_n = 1'b0; #2; rst_n = 1'b1;
        b2.in_valid = 4'hF;
        rcv = 0;
        for (int c = 0; c < 24; c++) begin
            b2.out_ready = (c % 3 != 1);
            @(negedge clk);
            if (b2.out_valid && !b2.out_ready)
                chk("t5_stall_rdy", b2.in_ready, 0);
            if (b2.out_valid && b2.out_ready) begin
                chk($sformatf("t5_g[%0d]", rcv), b2.grant, rcv % 4);
                chk($sformatf("t5_d[%0d]", rcv), b2.out_data, 32'hC000_0000 + (rcv % 4));
                rcv++;
            end
            @(posedge clk); #1;
        end
        chk("t5_count", rcv, 15);

        // T6: asynchronous reset mid-stream, restart from channel 0
        b2.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_pre_ov", b2.out_valid, 1);
        #1; rst_n = 1'b0;
        #1;
        chk("t6_ov", b2.out_valid, 0);
        chk("t6_d", b2.out_data, 0);
        chk("t6_g", b2.grant, 0);
        b2.in_valid = 4'b1100;
        @(negedge clk); rst_n = 1'b1;
        #1; chk("t6_rdy", b2.in_ready, 32'd1 << 2);
        @(posedge clk); #1;
        chk("t6_first_g", b2.grant, 2);
        chk("t6_first_d", b2.out_data, 32'hC000_0002);
        chk("t6_first_ov", b2.out_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
